// File: rtl/mux_share_arbiter.sv
// -----------------------------------------------------------------------------
// mux_share_arbiter
//   Round-robin arbiter that owns the select of a shared 2:1 mux
//   (out_data = sel ? data_b : data_a) and grants requester A or B for a
//   bounded burst of at most MAX_BURST transfers.
//
//   The datapath and the handshake signals are combinational. Only the
//   arbitration state is registered: FSM state, beat counter, last-served
//   pointer, and the decoded grant/select outputs.
//
// Parameters
//   WIDTH      data width of both requester ports and the output
//   MAX_BURST  beats per grant before forced re-arbitration (1..15)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   valid_a/data_a      requester A beat;  ready_a  A beat accepted
//   valid_b/data_b      requester B beat;  ready_b  B beat accepted
//   out_valid/out_data  muxed output beat; out_ready consumer accepts
//   sel                 mux select (0 = A, 1 = B), holds its value in IDLE
//   gnt_a, gnt_b        current grant holder
// -----------------------------------------------------------------------------
module mux_share_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             ready_a,
    input  logic             valid_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             ready_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             gnt_a,
    output logic             gnt_b
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    // A 4-bit counter covers the whole legal MAX_BURST range.
    localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_b_q, last_b_d;   // 1: B was served last
    logic       sel_q, gnt_a_q, gnt_b_q;

    logic       xfer;
    logic       full;
    logic       mine_v;
    logic       other_v;

    // ---------------------------------------------------------------- datapath
    assign sel       = sel_q;
    assign gnt_a     = gnt_a_q;
    assign gnt_b     = gnt_b_q;
    assign out_data  = sel_q ? data_b : data_a;
    assign out_valid = (gnt_a_q & valid_a) | (gnt_b_q & valid_b);
    assign ready_a   = gnt_a_q & out_ready;
    assign ready_b   = gnt_b_q & out_ready;

    assign xfer    = out_valid & out_ready;
    // The transfer that would take the count to MAX_BURST closes the burst.
    assign full    = xfer & (cnt_q == LAST_CNT);
    assign mine_v  = (state_q == GNT_B) ? valid_b : valid_a;
    assign other_v = (state_q == GNT_B) ? valid_a : valid_b;

    // -------------------------------------------------------------- next state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        case (state_q)
            IDLE: begin
                // On a tie, the requester not served last wins.
                if (valid_a && (!valid_b || last_b_q)) begin
                    state_d = GNT_A;
                end else if (valid_b) begin
                    state_d = GNT_B;
                end
            end
            GNT_A, GNT_B: begin
                if (full || !mine_v) begin
                    // Burst end: hand over directly if the other side waits,
                    // otherwise start a fresh burst or fall back to IDLE.
                    cnt_d    = '0;
                    last_b_d = (state_q == GNT_B);
                    if (other_v) begin
                        state_d = (state_q == GNT_B) ? GNT_A : GNT_B;
                    end else if (full) begin
                        state_d = state_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------ state
    // Grant and select are registered, decoded from the next state so they
    // line up with state_q on every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_b_q <= 1'b1;
            sel_q    <= 1'b0;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_b_q <= last_b_d;
            gnt_a_q  <= (state_d == GNT_A);
            gnt_b_q  <= (state_d == GNT_B);
            if (state_d != IDLE) begin
                sel_q <= (state_d == GNT_B);
            end
        end
    end

endmodule

// File: doc/mux_share_arbiter.md
Name: mux_share_arbiter

Overview:
- Round-robin arbiter that shares the team's 2:1 mux datapath (z = sel ? b : a) between two requesters, A and B, feeding a single downstream consumer.
- Owns the mux select. Grants one requester at a time for a bounded burst and forwards data with valid/ready handshakes on both sides.
- Sits between two producer blocks and one consumer. The datapath itself stays combinational; only arbitration state is registered.

Parameters:
- WIDTH, 8, data width of each requester port and the output.
- MAX_BURST, 4, maximum beats transferred per grant before forced re-arbitration (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_a  input  1  requester A has data.
- data_a  input  WIDTH  requester A data.
- ready_a  output  1  A's beat is accepted this cycle.
- valid_b  input  1  requester B has data.
- data_b  input  WIDTH  requester B data.
- ready_b  output  1  B's beat is accepted this cycle.
- out_valid  output  1  output beat valid.
- out_data  output  WIDTH  muxed data.
- out_ready  input  1  consumer accepts beat.
- sel  output  1  mux select: 0 = A, 1 = B.
- gnt_a  output  1  A holds the grant.
- gnt_b  output  1  B holds the grant.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sel=0, gnt_a=gnt_b=0, beat count=0, last-served pointer=B (so A wins the first tie). Consequently out_valid=0, ready_a=ready_b=0. Release is synchronous to clk.
- States:
  - IDLE: no grant.
  - GNT_A: gnt_a=1, sel=0.
  - GNT_B: gnt_b=1, sel=1.
  - sel, gnt_a and gnt_b are registered and decoded from state; sel holds its last value in IDLE.
- Datapath (combinational):
  - out_data = sel ? data_b : data_a.
  - out_valid = (gnt_a & valid_a) | (gnt_b & valid_b).
  - ready_a = gnt_a & out_ready; ready_b = gnt_b & out_ready.
  - A transfer occurs on a cycle with out_valid & out_ready.
- Ungranted requesters never see ready, and their data never reaches out_data while out_valid=1.
- IDLE transitions:
  - Only valid_a: go to GNT_A.
  - Only valid_b: go to GNT_B.
  - Both: grant the requester not last served.
  - Neither: stay in IDLE.
  - The grant appears on the next edge, so first-beat latency from valid to out_valid is 1 cycle.
- In GNT_x:
  - The beat counter increments on each transfer.
  - The burst ends on a cycle where either (a) a transfer takes the count to MAX_BURST, or (b) valid_x=0 (requester idle).
  - Stalls (out_ready=0 with valid_x=1) hold the grant indefinitely and do not count.
- At burst end:
  - Counter clears to 0 and the last-served pointer is set to x.
  - Next state: the other requester's grant if it is valid this cycle (direct handover, no IDLE bubble).
  - Else GNT_x again with a fresh burst, if (a) and valid_x is still 1.
  - Else IDLE.
- The grant never changes on a cycle that is not a burst end. A valid beat is never dropped or duplicated.
- Simultaneous rise of valid_a and valid_b in IDLE resolves purely by the pointer. With both continuously valid, grants alternate A, B, A… every MAX_BURST transfers.
- MAX_BURST=1: re-arbitration after every transfer.
- Reset mid-burst: grant is removed immediately (asynchronous) and the pointer returns to B. The in-flight beat is not transferred unless its out_ready edge occurred before reset assertion.

Test Plan:
- Reset then idle: rst_n=0 mid-cycle -> gnt_a=gnt_b=0, out_valid=0, sel=0 immediately; stays IDLE with valid_a=valid_b=0.
- Single requester: valid_a=1, data_a=8'h3C, out_ready=1 from cycle 0 -> gnt_a at cycle 1, out_data=8'h3C, out_valid=1. After 4 transfers, a fresh burst continues on A with no gap.
- Contention, MAX_BURST=4, both valid, out_ready=1: transfers go A×4 then B×4 then A×4, sel toggling 0→1→0 with zero idle cycles. The first grant goes to A.
- Backpressure: GNT_B with out_ready=0 for 5 cycles while valid_a=1 -> gnt_b held, ready_b=0, count unchanged. On out_ready=1, B completes its remaining beats before A is granted.
- Early release: GNT_A, valid_a drops after 2 transfers while valid_b=1 -> next edge gnt_b=1, sel=1, counter restarts at 0.
- Reset mid-burst after 3 A transfers -> grant removed at once. After release with both valid, A is granted first again (pointer reset).
